// File: rtl/board_queue_pkg.sv
// board_queue_pkg: shared board-word constants, field slices, ALU ops and queue FSM states
package board_queue_pkg;
  localparam int WIDTH = 44;
  localparam int BOARD_W = 36;
  localparam int META_HI = 43;
  localparam int META_LO = 36;
  typedef logic [WIDTH-1:0] board_word_t;
  typedef enum logic [2:0] {OP_NOP, OP_RIGHTN, OP_LEFTN, OP_UPN, OP_DOWNN} alu_op_t;
  typedef enum logic {Q_RUN, Q_FLUSH} q_state_t;
  function automatic int tile_lo(input int n);
    return BOARD_W - 4 * n;
  endfunction
endpackage

// File: rtl/board_match.sv
// board_match: DEPTH-way board-field compare against occupied entries, producing one hit bit
module board_match #(
  parameter int DEPTH = 16,
  parameter int BOARD_W = board_queue_pkg::BOARD_W
) (
  input  logic [BOARD_W-1:0] boards [DEPTH],
  input  logic [DEPTH-1:0]   valid,
  input  logic [BOARD_W-1:0] key,
  output logic               hit
);
  import board_queue_pkg::*;
  // OR-reduce the per-entry equality over the occupied slots
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (valid[i] && boards[i] == key);
  end
endmodule

// File: rtl/board_queue.sv
// board_queue: first-word-fall-through FIFO of ALU board words; BOARD_QUEUE_DUP_FILTER_EN drops duplicate boards
module board_queue #(
  parameter int WIDTH = board_queue_pkg::WIDTH,
  parameter int BOARD_W = board_queue_pkg::BOARD_W,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             dup_drop
);
  import board_queue_pkg::*;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  q_state_t state;
  logic push_fire, pop_fire, hit, store;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ready = state == Q_RUN && !full;
  assign pop_valid = state == Q_RUN && !empty;
  assign pop_data = pop_valid ? mem[rd_ptr] : '0;
  assign push_fire = push_valid & push_ready & !clear;
  assign pop_fire = pop_valid & pop_ready & !clear;
  assign store = push_fire & !hit;
`ifdef BOARD_QUEUE_DUP_FILTER_EN
  logic [DEPTH-1:0] occ;
  logic [BOARD_W-1:0] boards [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [AW-1:0] off;
    assign off = AW'(i) - rd_ptr;
    assign occ[i] = {1'b0, off} < count;
    assign boards[i] = mem[i][BOARD_W-1:0];
  end
  board_match #(.DEPTH(DEPTH), .BOARD_W(BOARD_W)) u_match (
    .boards(boards),
    .valid(occ),
    .key(push_data[BOARD_W-1:0]),
    .hit(hit)
  );
`else
  assign hit = 1'b0;
`endif
  // storage array is deliberately not reset; unoccupied slots are masked off
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_data;
  end
  // pointers, occupancy, sticky overflow, duplicate pulse and RUN/FLUSH control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
      dup_drop <= 1'b0;
      state <= Q_RUN;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
      dup_drop <= 1'b0;
      state <= Q_FLUSH;
    end else begin
      wr_ptr <= wr_ptr + AW'(store);
      rd_ptr <= rd_ptr + AW'(pop_fire);
      count <= count + (AW+1)'(store) - (AW+1)'(pop_fire);
      ovf_err <= ovf_err | (push_valid & full);
      dup_drop <= push_fire & hit;
      state <= Q_RUN;
    end
  end
endmodule
